ysyx_22040127_fetch: RTL and testbench

// - Instruction-fetch stage. It is the transmitter of the IF->ID valid/allowin pipeline interface.
// - Owns the PC and issues 32-bit fetches to the instruction memory port.
// - Buffers returned instructions in a small FIFO and presents them to decode as {inst[31:0], pc[31:0]}.
// - Redirects on the decode-stage branch/jump outcome and drops wrong-path fetches.

---
 rtl/ysyx_22040127_fetch_if.sv | 28 ++
 rtl/ysyx_22040127_fetch.sv | 146 ++++++++++++++
 tb/tb_ysyx_22040127_fetch.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040127_fetch_if.sv
// IF-stage port bundle: IF->ID handshake, redirect, instruction-memory port and status outputs.
interface ysyx_22040127_fetch_if;
  logic        id_allowin;
  logic        if_to_id_valid;
  logic [63:0] if_to_id_bus;
  logic        id_branch_taken;
  logic [31:0] id_branch_result;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        if_fault;
  logic [63:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;

  modport master (
    input  id_allowin, id_branch_taken, id_branch_result, inst_gnt, inst_rvalid, inst_rdata,
    output if_to_id_valid, if_to_id_bus, inst_req, inst_addr, if_fault, perf_fetch_cnt,
           perf_flush_cnt
  );

  modport slave (
    output id_allowin, id_branch_taken, id_branch_result, inst_gnt, inst_rvalid, inst_rdata,
    input  if_to_id_valid, if_to_id_bus, inst_req, inst_addr, if_fault, perf_fetch_cnt,
           perf_flush_cnt
  );
endinterface

// File: rtl/ysyx_22040127_fetch.sv
// Instruction-fetch stage: owns the PC, keeps requests in flight, buffers returns for decode.
// Optional performance counters are built only when FETCH_PERF_EN is defined.
module ysyx_22040127_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MAX_OUTST  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_22040127_fetch_if.master io_fetch
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] StBoot = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StHalt = 2'd2;

  logic [1:0]      r_state, w_state_d;
  logic [31:0]     r_pc;
  logic [CntW-1:0] r_outst, w_outst_d;
  logic [CntW-1:0] r_drop, w_drop_d;
  logic [CntW-1:0] r_cnt;
  logic [PtrW-1:0] r_wr, r_rd;
  logic [PtrW-1:0] r_aq_wr, r_aq_rd;
  logic [31:0]     r_fifo_inst [FIFO_DEPTH];
  logic [31:0]     r_fifo_pc   [FIFO_DEPTH];
  logic [31:0]     r_aq        [FIFO_DEPTH];

  logic          w_run, w_redir, w_redir_bad, w_req, w_gnt, w_rv;
  logic          w_drop_rsp, w_push, w_valid, w_pop;
  logic [CntW:0] w_occ;

  assign w_run       = (r_state == StRun);
  assign w_redir     = io_fetch.id_branch_taken && (r_state != StHalt) &&
                       (io_fetch.id_branch_result[1:0] == 2'b00);
  assign w_redir_bad = io_fetch.id_branch_taken && (r_state != StHalt) &&
                       (io_fetch.id_branch_result[1:0] != 2'b00);

  // Buffer space is reserved at issue time, so a response can always be pushed.
  assign w_occ = {1'b0, r_outst} + {1'b0, r_cnt};
  assign w_req = w_run && (r_outst < CntW'(MAX_OUTST)) && (w_occ < (CntW + 1)'(FIFO_DEPTH));

  assign w_gnt      = w_req && io_fetch.inst_gnt;
  assign w_rv       = io_fetch.inst_rvalid && (r_outst != '0);
  assign w_drop_rsp = w_rv && ((r_drop != '0) || w_redir);
  assign w_push     = w_rv && !w_drop_rsp && w_run;
  assign w_valid    = w_run && (r_cnt != '0);
  assign w_pop      = w_valid && io_fetch.id_allowin;

  always_comb begin
    w_outst_d = r_outst + CntW'(w_gnt) - CntW'(w_rv);
    w_drop_d  = r_drop;
    if (w_redir) begin
      // Everything still in flight after this edge belongs to the old path.
      w_drop_d = w_outst_d;
    end else if (w_rv && (r_drop != '0)) begin
      w_drop_d = r_drop - CntW'(1);
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StBoot:  w_state_d = w_redir_bad ? StHalt : StRun;
      StRun:   w_state_d = w_redir_bad ? StHalt : StRun;
      default: w_state_d = r_state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StBoot;
      r_pc    <= RESET_PC;
      r_outst <= '0;
      r_drop  <= '0;
      r_cnt   <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_aq_wr <= '0;
      r_aq_rd <= '0;
    end else begin
      r_state <= w_state_d;
      r_outst <= w_outst_d;
      r_drop  <= w_drop_d;
      if (w_redir) begin
        r_pc <= io_fetch.id_branch_result;
      end else if (w_gnt) begin
        r_pc <= r_pc + 32'd4;
      end
      if (w_gnt) r_aq_wr <= r_aq_wr + PtrW'(1);
      if (w_rv)  r_aq_rd <= r_aq_rd + PtrW'(1);
      if (w_redir) begin
        r_wr  <= '0;
        r_rd  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push) r_wr <= r_wr + PtrW'(1);
        if (w_pop)  r_rd <= r_rd + PtrW'(1);
        r_cnt <= r_cnt + CntW'(w_push) - CntW'(w_pop);
      end
    end
  end

  // Request addresses stay queued until their response returns, dropped or not.
  always_ff @(posedge clk) begin
    if (w_gnt) r_aq[r_aq_wr] <= r_pc;
    if (w_push) begin
      r_fifo_inst[r_wr] <= io_fetch.inst_rdata;
      r_fifo_pc[r_wr]   <= r_aq[r_aq_rd];
    end
  end

  assign io_fetch.if_to_id_valid = w_valid;
  assign io_fetch.if_to_id_bus   = (r_cnt != '0) ? {r_fifo_inst[r_rd], r_fifo_pc[r_rd]} : 64'd0;
  assign io_fetch.inst_req       = w_req;
  assign io_fetch.inst_addr      = r_pc;
  assign io_fetch.if_fault       = (r_state == StHalt);

`ifdef FETCH_PERF_EN
  logic [63:0] r_perf_fetch;
  logic [31:0] r_perf_flush;
  logic [1:0]  w_flush_inc;
  logic [32:0] w_flush_sum;

  assign w_flush_inc = {1'b0, w_redir} + {1'b0, w_drop_rsp};
  assign w_flush_sum = {1'b0, r_perf_flush} + 33'(w_flush_inc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetch <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_pop && (r_perf_fetch != '1)) r_perf_fetch <= r_perf_fetch + 64'd1;
      r_perf_flush <= w_flush_sum[32] ? '1 : w_flush_sum[31:0];
    end
  end

  assign io_fetch.perf_fetch_cnt = r_perf_fetch;
  assign io_fetch.perf_flush_cnt = r_perf_flush;
`else
  assign io_fetch.perf_fetch_cnt = 64'd0;
  assign io_fetch.perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ysyx_22040127_fetch.sv
// Directed bench for ysyx_22040127_fetch: memory responder, request model and bundle scoreboard.
module tb_ysyx_22040127_fetch;
  localparam logic [31:0] ResetPc = 32'h8000_0000;
  localparam logic [31:0] Magic   = 32'h5A5A_0F0F;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ysyx_22040127_fetch_if f ();

  ysyx_22040127_fetch dut (
    .clk      (clk),
    .rst      (rst),
    .io_fetch (f)
  );

  int          checks = 0;
  int          failures = 0;
  pend_t       pend_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] exp_pc;
  int          cyc;
  bit          booting, halted;
  bit          gnt_rand, allow_rand, allow_v;
  int          lat_min, lat_max;
  bit          br_now, br_arm;
  logic [31:0] br_tgt;
  int          n_pop, n_flush, n_drop, first_valid, drop0;
  bit          want_first, have_last;
  logic [31:0] last_pc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic gnt, input logic allow, input logic rv, input logic [31:0] rd,
                       input logic br);
    f.inst_gnt         = gnt;
    f.id_allowin       = allow;
    f.inst_rvalid      = rv;
    f.inst_rdata       = rd;
    f.id_branch_taken  = br;
    f.id_branch_result = br_tgt;
  endtask

  // Asynchronous reset asserted mid-low-phase; outputs are checked before any clock edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    #1;
    check("rst_inst_req", f.inst_req, 1'b0);
    check("rst_inst_addr", f.inst_addr, ResetPc);
    check("rst_valid", f.if_to_id_valid, 1'b0);
    check("rst_bus", f.if_to_id_bus, 64'd0);
    check("rst_fault", f.if_fault, 1'b0);
    check("rst_perf_fetch", f.perf_fetch_cnt, 64'd0);
    check("rst_perf_flush", f.perf_flush_cnt, 32'd0);
    pend_q.delete();
    exp_q.delete();
    exp_pc = ResetPc; cyc = 0; booting = 1'b1; halted = 1'b0;
    n_pop = 0; n_flush = 0; n_drop = 0; first_valid = -1;
    want_first = 1'b0; have_last = 1'b0; br_now = 1'b0; br_arm = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One cycle: sample at negedge, check against the model, drive inputs, advance.
  task automatic step();
    logic req, vld, gnt, allow, rv, br, exp_req, redir, bad;
    logic [31:0] addr, rdata;
    logic [63:0] bus, exp;
    pend_t p;
    req   = f.inst_req;
    addr  = f.inst_addr;
    vld   = f.if_to_id_valid;
    bus   = f.if_to_id_bus;
    gnt   = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    allow = allow_rand ? 1'($urandom_range(0, 1)) : allow_v;
    br    = br_now;
    br_now = 1'b0;
    if (br_arm && req && pend_q.size() == 1) begin
      br = 1'b1;
      br_arm = 1'b0;
    end
    exp_req = !booting && !halted && (pend_q.size() < 2) && (pend_q.size() + exp_q.size() < 2);
    rv = 1'b0;
    rdata = 32'd0;
    p = '{addr: 32'd0, due: 0, stale: 1'b0};
    if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
      p = pend_q.pop_front();
      rv = 1'b1;
      rdata = p.addr ^ Magic;
    end

    check("inst_req", req, exp_req);
    check("if_fault", f.if_fault, halted);
    if (req) check("inst_addr", addr, exp_pc);
    if (halted) check("valid_in_halt", vld, 1'b0);
    else check("if_to_id_valid", vld, exp_q.size() != 0);
    if (!vld && !halted && exp_q.size() == 0) check("bus_zero_empty", bus, 64'd0);
    if (vld && first_valid < 0) first_valid = cyc;
    if (vld && allow) begin
      n_pop++;
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        check("bundle", bus, exp);
      end
      if (want_first) begin
        check("redirect_first_pc", bus[31:0], br_tgt);
        want_first = 1'b0;
      end
      if (have_last) check("pc_contiguous", bus[31:0], last_pc + 32'd4);
      last_pc = bus[31:0];
      have_last = 1'b1;
    end

    redir = br && !halted && (br_tgt[1:0] == 2'b00);
    bad   = br && !halted && (br_tgt[1:0] != 2'b00);
    if (redir) foreach (pend_q[i]) pend_q[i].stale = 1'b1;
    if (req && gnt) begin
      pend_q.push_back('{addr: exp_pc, due: cyc + int'($urandom_range(lat_max, lat_min)),
                         stale: redir});
      exp_pc = exp_pc + 32'd4;
    end
    if (rv) begin
      if (p.stale || redir) begin
        n_drop++;
        n_flush++;
      end else if (!halted) begin
        exp_q.push_back({rdata, p.addr});
      end
    end
    if (redir) begin
      exp_pc = br_tgt;
      exp_q.delete();
      n_flush++;
      have_last = 1'b0;
      want_first = 1'b1;
    end
    if (bad) halted = 1'b1;

    drive(gnt, allow, rv, rdata, br);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    booting = 1'b0;
  endtask

  initial begin
    br_tgt = 32'd0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    gnt_rand = 1'b0; allow_rand = 1'b0; allow_v = 1'b1;
    lat_min = 1; lat_max = 1;

    // Streaming with immediate grant and 1-cycle responses.
    do_reset();
    repeat (20) step();
    check("first_valid_cycle", 64'(first_valid), 64'd3);

    // Back-pressure fills the buffer, then drains in order.
    allow_v = 1'b0;
    repeat (10) step();
    check("full_req_low", f.inst_req, 1'b0);
    check("full_valid_high", f.if_to_id_valid, 1'b1);
    allow_v = 1'b1;
    repeat (10) step();

    // Redirect with one outstanding request plus a same-cycle grant.
    lat_min = 3; lat_max = 3;
    drop0 = n_drop;
    br_tgt = 32'h8000_1000;
    br_arm = 1'b1;
    for (int i = 0; i < 30 && br_arm; i++) step();
    check("redirect_fired", br_arm, 1'b0);
    repeat (20) step();
    check("dropped_responses", 64'(n_drop - drop0), 64'd2);
    check("redirect_pc_seen", want_first, 1'b0);
`ifdef FETCH_PERF_EN
    check("perf_fetch", f.perf_fetch_cnt, 64'(n_pop));
    check("perf_flush", f.perf_flush_cnt, 64'(n_flush));
`else
    check("perf_fetch_off", f.perf_fetch_cnt, 64'd0);
    check("perf_flush_off", f.perf_flush_cnt, 64'd0);
`endif

    // Random grant, latency and back-pressure.
    gnt_rand = 1'b1; allow_rand = 1'b1; lat_min = 1; lat_max = 4;
    repeat (300) step();
    gnt_rand = 1'b0; allow_rand = 1'b0;
    repeat (10) step();

    // Redirect while still in the boot cycle.
    lat_min = 1; lat_max = 1;
    do_reset();
    br_tgt = 32'h8000_2000;
    br_now = 1'b1;
    repeat (10) step();
    check("boot_redirect_seen", want_first, 1'b0);

    // Misaligned redirect halts until reset.
    repeat (5) step();
    br_tgt = 32'h8000_0102;
    br_now = 1'b1;
    repeat (20) step();
    check("fault_sticky", f.if_fault, 1'b1);
    check("halt_req_low", f.inst_req, 1'b0);
    do_reset();
    repeat (8) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
